// File: rtl/jtag_host.sv
// JTAG initiator: walks a target TAP from Run-Test/Idle through one IR or DR
// shift and back, returning the captured TDO bits. tck is clk/2.
module jtag_host #(
  parameter int MAX_LEN = 32
) (
  input  logic               clk_i,
  input  logic               trst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_ir_i,
  input  logic [5:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int CW = 7;
  localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);
  localparam logic [CW-1:0] INIT_LAST = 7'd5;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [5:0]         len_q, len_d;
  logic               ir_q, ir_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               ready_q, ready_d;

  logic [5:0]         len_clamp;
  logic [MAX_LEN-1:0] cap_upd;
  logic [CW-1:0]      pre_len, shift_end, scan_last, nxt;
  logic               in_shift, nxt_shift, nxt_tms;

  assign len_clamp = (cmd_len_i > MAX_LEN_L) ? MAX_LEN_L : cmd_len_i;

  // mask_q is one-hot on the bit position of the current shift cycle
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cap
    assign cap_upd[gi] = cap_q[gi] | (mask_q[gi] & tdo_i);
  end

  // Scan cycle layout: [0, pre_len) preamble, [pre_len, shift_end) shift,
  // then Update and Run-Test/Idle.
  always_comb begin
    pre_len   = ir_q ? 7'd4 : 7'd3;
    shift_end = pre_len + {1'b0, len_q};
    scan_last = shift_end + 7'd1;
    nxt       = cyc_q + 7'd1;
    in_shift  = (cyc_q >= pre_len) && (cyc_q < shift_end);
    nxt_shift = (nxt >= pre_len) && (nxt < shift_end);
    if (nxt < pre_len) begin
      nxt_tms = ir_q ? (nxt < 7'd2) : (nxt == 7'd0);
    end else if (nxt < shift_end) begin
      nxt_tms = (nxt == shift_end - 7'd1);
    end else begin
      nxt_tms = (nxt == shift_end);
    end
  end

  always_comb begin
    state_d     = state_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cyc_d       = cyc_q;
    len_d       = len_q;
    ir_d        = ir_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ready_d     = ready_q;

    unique case (state_q)
      ST_INIT: begin
        if (!tck_q) begin
          tck_d = 1'b1;
        end else begin
          tck_d = 1'b0;
          if (cyc_q == INIT_LAST) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            tms_d   = 1'b0;
            cyc_d   = '0;
          end else begin
            cyc_d = nxt;
            tms_d = (nxt != INIT_LAST);
          end
        end
      end

      ST_IDLE: begin
        tck_d = 1'b0;
        tdi_d = 1'b0;
        tms_d = 1'b0;
        if (cmd_valid_i && ready_q) begin
          ready_d = 1'b0;
          ir_d    = cmd_ir_i;
          len_d   = len_clamp;
          data_d  = cmd_data_i;
          mask_d  = {{(MAX_LEN-1){1'b0}}, 1'b1};
          cap_d   = '0;
          cyc_d   = '0;
          // Both IR and DR sequences begin with tms=1 (Select-DR-Scan)
          tms_d   = (len_clamp != 6'd0);
          state_d = (len_clamp == 6'd0) ? ST_DONE : ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!tck_q) begin
          tck_d = 1'b1;
          if (in_shift) begin
            cap_d  = cap_upd;
            mask_d = mask_q << 1;
          end
        end else begin
          tck_d = 1'b0;
          if (cyc_q == scan_last) begin
            state_d     = ST_IDLE;
            rsp_data_d  = cap_q;
            rsp_valid_d = 1'b1;
            ready_d     = 1'b1;
            tms_d       = 1'b0;
            tdi_d       = 1'b0;
          end else begin
            cyc_d = nxt;
            tms_d = nxt_tms;
            if (nxt_shift) begin
              tdi_d  = data_q[0];
              data_d = data_q >> 1;
            end else begin
              tdi_d = 1'b0;
            end
          end
        end
      end

      ST_DONE: begin
        rsp_data_d  = cap_q;
        rsp_valid_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge trst_i) begin
    if (trst_i) begin
      state_q     <= ST_INIT;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cyc_q       <= '0;
      len_q       <= '0;
      ir_q        <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cyc_q       <= cyc_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host driving a behavioural TAP with a 1-bit BYPASS
// data register and a 4-bit IR that captures 4'b0001.
module tb_jtag_host;

  logic        clk = 1'b0;
  logic        trst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_ir = 1'b0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  int checks = 0;
  int errors = 0;

  jtag_host #(.MAX_LEN(32)) dut (
    .clk_i(clk), .trst_i(trst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_ir_i(cmd_ir), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
  );

  always #5 clk = ~clk;

  // Target TAP
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
  tap_e       tap_st = TLR;
  logic       byp = 1'b0;
  logic [3:0] ir_sr = 4'b0;

  always @(posedge tck) begin
    case (tap_st)
      CAPDR: byp <= 1'b0;
      SHDR:  byp <= tdi;
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
      default: ;
    endcase
    case (tap_st)
      TLR:   tap_st <= tms ? TLR   : RTI;
      RTI:   tap_st <= tms ? SELDR : RTI;
      SELDR: tap_st <= tms ? SELIR : CAPDR;
      CAPDR: tap_st <= tms ? EX1DR : SHDR;
      SHDR:  tap_st <= tms ? EX1DR : SHDR;
      EX1DR: tap_st <= tms ? UPDR  : PADR;
      PADR:  tap_st <= tms ? EX2DR : PADR;
      EX2DR: tap_st <= tms ? UPDR  : SHDR;
      UPDR:  tap_st <= tms ? SELDR : RTI;
      SELIR: tap_st <= tms ? TLR   : CAPIR;
      CAPIR: tap_st <= tms ? EX1IR : SHIR;
      SHIR:  tap_st <= tms ? EX1IR : SHIR;
      EX1IR: tap_st <= tms ? UPIR  : PAIR;
      PAIR:  tap_st <= tms ? EX2IR : PAIR;
      EX2IR: tap_st <= tms ? UPIR  : SHIR;
      default: tap_st <= tms ? SELDR : RTI;
    endcase
  end

  always @(negedge tck) begin
    tdo <= (tap_st == SHDR) ? byp : ((tap_st == SHIR) ? ir_sr[0] : 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and records what happens; lat is cycles from the
  // accept edge to rsp_valid, -1 if it never came.
  task automatic run_cmd(input logic ir, input logic [5:0] len, input logic [31:0] data,
                         output int lat, output int rises, output int pulses,
                         output logic [31:0] rsp, output logic [63:0] tms_seq,
                         output logic tck_at_rsp);
    int w;
    logic prev;
    lat = -1; rises = 0; pulses = 0; rsp = '0; tms_seq = '0; tck_at_rsp = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    cmd_valid = 1'b1; cmd_ir = ir; cmd_len = len; cmd_data = data;
    tick();
    cmd_valid = 1'b0; cmd_data = 32'hDEAD_BEEF;
    prev = tck;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (tck && !prev) begin
        if (rises < 64) tms_seq[rises] = tms;
        rises++;
      end
      prev = tck;
      if (rsp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k; rsp = rsp_data; tck_at_rsp = tck;
        end
      end
      if (lat >= 0 && k >= lat + 4) break;
    end
    $display("scan ir=%0d len=%0d data=%h -> rsp=%h lat=%0d rises=%0d", ir, len, data, rsp, lat, rises);
  endtask

  task automatic test_reset();
    trst = 1'b1;
    repeat (3) tick();
    checks += 6;
    if (tck !== 1'b0) begin errors++; $display("FAIL reset_tck: got %b expected 0", tck); end
    if (tms !== 1'b1) begin errors++; $display("FAIL reset_tms: got %b expected 1", tms); end
    if (tdi !== 1'b0) begin errors++; $display("FAIL reset_tdi: got %b expected 0", tdi); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    trst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks += 3;
      if (tck !== ((e % 2 == 1) && e <= 11)) begin
        errors++; $display("FAIL init_tck edge %0d: got %b", e, tck);
      end
      if (tms !== (e < 10)) begin
        errors++; $display("FAIL init_tms edge %0d: got %b", e, tms);
      end
      if (cmd_ready !== (e >= 12)) begin
        errors++; $display("FAIL init_ready edge %0d: got %b", e, cmd_ready);
      end
    end
    checks++;
    if (tap_st !== RTI) begin errors++; $display("FAIL init_tap_state: got %0d expected %0d", tap_st, RTI); end
    $display("init sequence observed after reset release");
  endtask

  task automatic test_dr_bypass();
    int lat, rises, pulses; logic [31:0] rsp; logic [63:0] ts; logic tk;
    run_cmd(1'b0, 6'd8, 32'hA5, lat, rises, pulses, rsp, ts, tk);
    checks += 7;
    if (rsp !== 32'h4A) begin errors++; $display("FAIL dr8_rsp: got %h expected 4a", rsp); end
    if (lat !== 26) begin errors++; $display("FAIL dr8_latency: got %0d expected 26", lat); end
    if (pulses !== 1) begin errors++; $display("FAIL dr8_pulses: got %0d expected 1", pulses); end
    if (rises !== 13) begin errors++; $display("FAIL dr8_rises: got %0d expected 13", rises); end
    if (ts[12:0] !== 13'h0C01) begin errors++; $display("FAIL dr8_tms: got %h expected 0c01", ts[12:0]); end
    if (tk !== 1'b0) begin errors++; $display("FAIL dr8_tck_at_rsp: got %b expected 0", tk); end
    if (tap_st !== RTI) begin errors++; $display("FAIL dr8_tap_state: got %0d expected %0d", tap_st, RTI); end
  endtask

  task automatic test_ir_scan();
    int lat, rises, pulses; logic [31:0] rsp; logic [63:0] ts; logic tk;
    run_cmd(1'b1, 6'd4, 32'hF, lat, rises, pulses, rsp, ts, tk);
    checks += 6;
    if (rsp !== 32'h1) begin errors++; $display("FAIL ir4_rsp: got %h expected 1", rsp); end
    if (lat !== 20) begin errors++; $display("FAIL ir4_latency: got %0d expected 20", lat); end
    if (pulses !== 1) begin errors++; $display("FAIL ir4_pulses: got %0d expected 1", pulses); end
    if (rises !== 10) begin errors++; $display("FAIL ir4_rises: got %0d expected 10", rises); end
    if (ts[9:0] !== 10'h183) begin errors++; $display("FAIL ir4_tms: got %h expected 183", ts[9:0]); end
    if (tap_st !== RTI) begin errors++; $display("FAIL ir4_tap_state: got %0d expected %0d", tap_st, RTI); end
  endtask

  task automatic test_clamp();
    int lat, rises, pulses; logic [31:0] rsp; logic [63:0] ts; logic tk;
    run_cmd(1'b0, 6'd40, 32'h1234_5678, lat, rises, pulses, rsp, ts, tk);
    checks += 4;
    if (rsp !== 32'h2468_ACF0) begin errors++; $display("FAIL clamp_rsp: got %h expected 2468acf0", rsp); end
    if (rises !== 37) begin errors++; $display("FAIL clamp_rises: got %0d expected 37", rises); end
    if (lat !== 74) begin errors++; $display("FAIL clamp_latency: got %0d expected 74", lat); end
    if (ts[36:0] !== 37'h0C_0000_0001) begin errors++; $display("FAIL clamp_tms: got %h expected 0c00000001", ts[36:0]); end
  endtask

  task automatic test_len_zero();
    int lat, rises, pulses; logic [31:0] rsp; logic [63:0] ts; logic tk;
    run_cmd(1'b0, 6'd0, 32'hFFFF_FFFF, lat, rises, pulses, rsp, ts, tk);
    checks += 4;
    if (lat !== 1) begin errors++; $display("FAIL len0_latency: got %0d expected 1", lat); end
    if (rises !== 0) begin errors++; $display("FAIL len0_rises: got %0d expected 0", rises); end
    if (rsp !== 32'h0) begin errors++; $display("FAIL len0_rsp: got %h expected 0", rsp); end
    if (pulses !== 1) begin errors++; $display("FAIL len0_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int first, second, w;
    logic [31:0] rsp1, rsp2;
    logic rdy_after, tms_after;
    first = -1; second = -1; rsp1 = '0; rsp2 = '0; rdy_after = 1'b1; tms_after = 1'b0;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    cmd_valid = 1'b1; cmd_ir = 1'b0; cmd_len = 6'd3; cmd_data = 32'h5;
    tick();
    // Held valid with new contents: ignored until the first scan completes
    cmd_ir = 1'b1; cmd_len = 6'd4; cmd_data = 32'h5;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (rsp_valid) begin
        if (first < 0) begin first = k; rsp1 = rsp_data; end
        else if (second < 0) begin second = k; rsp2 = rsp_data; end
      end
      if (first >= 0 && k == first + 1) begin
        rdy_after = cmd_ready; tms_after = tms; cmd_valid = 1'b0;
      end
      if (second >= 0) break;
    end
    cmd_valid = 1'b0;
    $display("back-to-back: rsp1=%h at %0d, rsp2=%h at %0d", rsp1, first, rsp2, second);
    checks += 6;
    if (first !== 16) begin errors++; $display("FAIL b2b_first_lat: got %0d expected 16", first); end
    if (rsp1 !== 32'h2) begin errors++; $display("FAIL b2b_rsp1: got %h expected 2", rsp1); end
    if (rdy_after !== 1'b0) begin errors++; $display("FAIL b2b_accept_ready: got %b expected 0", rdy_after); end
    if (tms_after !== 1'b1) begin errors++; $display("FAIL b2b_accept_tms: got %b expected 1", tms_after); end
    if (second !== 37) begin errors++; $display("FAIL b2b_second_lat: got %0d expected 37", second); end
    if (rsp2 !== 32'h1) begin errors++; $display("FAIL b2b_rsp2: got %h expected 1", rsp2); end
  endtask

  task automatic test_trst_abort();
    int w, rv, rises, rdy_edge, lat, r2, pulses;
    logic prev, tck_before;
    logic [31:0] rsp; logic [63:0] ts; logic tk;
    rv = 0; rises = 0; rdy_edge = -1;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    cmd_valid = 1'b1; cmd_ir = 1'b0; cmd_len = 6'd16; cmd_data = 32'hBEEF;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (rsp_valid) rv++;
    end
    tck_before = tck;
    trst = 1'b1;
    #1;
    checks += 5;
    if (tck_before !== 1'b1) begin errors++; $display("FAIL abort_tck_before: got %b expected 1", tck_before); end
    if (tck !== 1'b0) begin errors++; $display("FAIL abort_tck: got %b expected 0", tck); end
    if (tms !== 1'b1) begin errors++; $display("FAIL abort_tms: got %b expected 1", tms); end
    if (tdi !== 1'b0) begin errors++; $display("FAIL abort_tdi: got %b expected 0", tdi); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", cmd_ready); end
    repeat (3) begin tick(); if (rsp_valid) rv++; end
    trst = 1'b0;
    prev = tck;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (tck && !prev) rises++;
      prev = tck;
      if (rsp_valid) rv++;
      if (cmd_ready && rdy_edge < 0) rdy_edge = e;
    end
    $display("abort: rsp_valid pulses=%0d init rises=%0d ready edge=%0d", rv, rises, rdy_edge);
    checks += 3;
    if (rv !== 0) begin errors++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", rv); end
    if (rises !== 6) begin errors++; $display("FAIL abort_init_rises: got %0d expected 6", rises); end
    if (rdy_edge !== 12) begin errors++; $display("FAIL abort_ready_edge: got %0d expected 12", rdy_edge); end
    run_cmd(1'b0, 6'd8, 32'h3C, lat, r2, pulses, rsp, ts, tk);
    checks += 2;
    if (rsp !== 32'h78) begin errors++; $display("FAIL abort_rescan_rsp: got %h expected 78", rsp); end
    if (lat !== 26) begin errors++; $display("FAIL abort_rescan_latency: got %0d expected 26", lat); end
  endtask

  initial begin
    test_reset();
    test_dr_bypass();
    test_ir_scan();
    test_clamp();
    test_len_zero();
    test_back_to_back();
    test_trst_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_host.md
# jtag_host

JTAG initiator that drives a target TAP (such as the on-chip `jtag` TAP) over tck/tms/tdi/tdo. It accepts one IR or DR scan command at a time, walks the TAP state machine from Run-Test/Idle through the shift state and back, and returns the captured TDO bits. It sits between a system-side command source (test logic or a bus bridge) and the four JTAG pins. It runs entirely on the system clock; tck is a divided copy of that clock.

## Interface
- MAX_LEN, 32: maximum scan length in bits. Also the width of cmd_data and rsp_data.
- clk  in  1  system clock. tck runs at clk/2.
- trst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  host idle in Run-Test/Idle; a command is accepted when cmd_valid & cmd_ready.
- cmd_ir  in  1  1 = IR scan, 0 = DR scan.
- cmd_len  in  6  number of bits to shift. 0 = no scan; values above MAX_LEN are clamped to MAX_LEN.
- cmd_data  in  MAX_LEN  TDI bits, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse when a scan completes.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB first. Bits at or above len are 0. Held until the next rsp_valid.
- tck  out  1  JTAG clock to the target.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to the target.
- tdo  in  1  JTAG data from the target.

## Operation
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
- States: INIT, IDLE, SCAN, DONE.
- INIT (entered on reset):
  - 5 tck cycles with tms=1 (forces Test-Logic-Reset), then 1 tck cycle with tms=0 (Run-Test/Idle).
  - Then go to IDLE.
- IDLE:
  - tck parked at 0, tms=0, tdi=0, cmd_ready=1.
  - On accept: latch cmd_ir, the clamped len and cmd_data, then go to SCAN.
  - If len=0: go directly to DONE. No tck activity; rsp_data=0.
- SCAN tms sequence, one bit per tck cycle:
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0 (adds Select-IR).
  - Shift: len cycles. tms=0, except tms=1 on the last shift cycle (Exit1).
  - Exit: 1,0 (Update, Run-Test/Idle).
  - Total tck cycles: DR = len+5, IR = len+6.
- Shift cycle i (0-based):
  - tdi = data[i].
  - tdo is sampled into rsp_data[i] on the clk edge where tck rises.
  - Outside shift cycles, tdi=0.
- DONE: pulse rsp_valid for one cycle, set cmd_ready=1, return to IDLE.
- cmd_valid while cmd_ready=0 is ignored. It is not queued.
- trst asserted at any point aborts the current scan:
  - outputs return to their reset values at once;
  - no rsp_valid is produced for the aborted command;
  - INIT reruns after release.

## Timing
- Each tck cycle is 2 clk cycles: a low phase, then a high phase.
- tms and tdi change only on the clk edge that drives tck low (or holds it low). They are stable across the rising edge of tck.
- tdo is sampled on the same clk edge that drives tck high.
- INIT after trst release:
  - tck rises on edges 1, 3, 5, 7, 9, 11.
  - tms=1 until edge 10; tms=0 from edge 10.
  - cmd_ready=1 from edge 12.
- Scan, with the accept edge called A:
  - On edge A, tms and tdi take the first sequence bit and tck stays 0.
  - tck rises on A+1, A+3, and so on.
  - rsp_valid and cmd_ready rise on A+2(len+5) for DR, A+2(len+6) for IR. tck is 0 at that point.
- len=0: rsp_valid on A+1.
- Back-to-back commands: the earliest next accept is the edge after rsp_valid rises.

## Test plan
- Release reset with tdo=0 → 6 tck rising edges on clk edges 1–11, tms sampled 1,1,1,1,1,0, cmd_ready rises on edge 12, tck then stays 0.
- DR scan, len=8, data=0xA5, into a jtag TAP with BYPASS selected → rsp_data=0x4A; rsp_valid is a single pulse 26 cycles after accept.
- IR scan, len=4, data=0xF, into a jtag TAP with IR capture value 4'b0001 → rsp_data=0x1; tms sampled 1,1,0,0,0,0,0,1,1,0; rsp_valid 20 cycles after accept.
- DR scan with len=40 → clamped to 32; exactly 32 shift cycles and 37 tck rising edges.
- DR scan with len=0 → no tck edges; rsp_valid on A+1; rsp_data=0.
- Assert trst mid-shift of a 16-bit DR scan → tck=0 and tms=1 immediately, no rsp_valid, INIT sequence repeats after release, then a fresh BYPASS scan returns the correct result.
